// File: rtl/btn_debouncer.sv
// btn_debouncer: per-lane 2-FF synchronizer plus stability counter
// that yields clean button levels and one-cycle press/release pulses.
module btn_debouncer #(
    parameter int N_BTNS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTNS-1:0] btns_raw,
    output logic [N_BTNS-1:0] btns_clean,
    output logic [N_BTNS-1:0] press_pulse,
    output logic [N_BTNS-1:0] release_pulse
);

    // Lane state = {clean level, counting-or-mismatched}
    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] CNT_HI    = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] CNT_LO    = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_BTNS-1:0] sync1;
    logic [N_BTNS-1:0] sync2;

    // Two-flop synchronizer; only sync2 is seen by the lane logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btns_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTNS; i++) begin : g_lane
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             clean;
        logic             press;
        logic             rel;
        logic             busy;
        logic             accept;
        logic [1:0]       state;

        assign busy  = (cnt != '0) || (sync2[i] != clean);
        assign state = {clean, busy};

        // Next count and acceptance from the lane state
        always_comb begin
            cnt_nxt = '0;
            accept  = 1'b0;
            unique case (state)
                STABLE_LO, STABLE_HI: begin
                    cnt_nxt = '0;
                end
                CNT_HI, CNT_LO: begin
                    if (sync2[i] == clean) begin
                        cnt_nxt = '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            endcase
        end

        // Counter, accepted level and registered edge pulses
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                clean <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                cnt   <= cnt_nxt;
                press <= accept & sync2[i];
                rel   <= accept & ~sync2[i];
                if (accept) begin
                    clean <= sync2[i];
                end
            end
        end

        assign btns_clean[i]    = clean;
        assign press_pulse[i]   = press;
        assign release_pulse[i] = rel;
    end

endmodule
